dma_channel_arbiter: RTL and testbench
======================================

Name: dma_channel_arbiter

Overview:
- Round-robin arbiter for the 8 DMA channel request lines.
- Selects one requesting channel and holds it for a programmable burst of beats.
- Emits the winner as a 3-bit binary index `grant_idx`. The existing 3-to-8 decoder consumes this index and produces the one-hot channel enable.
- Sits directly upstream of that decoder, between the channel request logic and the datapath beat counter.

Parameters:
- N_CH, 8, number of channels; fixed at 8 so the index is exactly 3 bits for the decoder.
- BURST_W, 4, width of burst_len. A value of 0 encodes 2^BURST_W beats (16).
- TIMEOUT, 32, cycles without a beat in XFER before forced release.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  level request per channel; bit i = channel i.
- burst_len  input  BURST_W  beats for the next grant; sampled only on the IDLE->XFER transition.
- beat  input  1  datapath completed one beat for the granted channel this cycle.
- abort  input  1  software abort of the current burst.
- grant_idx  output  3  binary index of the granted channel; feeds the 3-to-8 decoder.
- grant_valid  output  1  grant_idx is valid and the channel owns the bus.
- done  output  1  one-cycle pulse at end of burst.
- done_err  output  1  valid with done: 1 = ended by abort, timeout or request drop.
- busy  output  1  high in XFER and DONE.

Behaviour:
- Reset (synchronous, active-high, sampled at clk edge):
  - state=IDLE, grant_idx=3'd0, grant_valid=0, done=0, done_err=0, busy=0.
  - last_ptr=3'd7, so channel 0 has first priority after reset.
  - beat counter=0, timeout counter=0.
  - Reset asserted mid-burst abandons the burst immediately with no done pulse.
- States:
  - IDLE: if req != 0, pick the first set bit searching upward from last_ptr+1 with wrap 7->0. Register the winner into grant_idx. Load cnt from burst_len (0 -> 16). Clear the timeout counter. Go to XFER. Latency req->grant_valid = 1 cycle.
  - XFER: grant_valid=1, busy=1, grant_idx stable.
    - beat=1: cnt decrements and the timeout counter clears.
    - beat=1 with cnt==1: go to DONE, err=0.
    - Otherwise the timeout counter increments; reaching TIMEOUT-1 goes to DONE with err=1.
  - DONE: grant_valid=0, done=1, done_err as recorded, busy=1. last_ptr<=grant_idx. Next state IDLE unconditionally. No re-arbitration in this cycle, so there is minimum one idle cycle between bursts.
- Priority inside XFER, same cycle: reset > abort > request drop (req[grant_idx]==0) > final beat > timeout.
  - abort or request drop -> DONE with err=1, even if beat is also high on the final count.
  - A beat on a cycle that takes an abort or drop is still counted as transferred by the datapath. The arbiter ignores it.
- Other boundary rules:
  - beat while in IDLE or DONE is ignored.
  - abort while in IDLE or DONE is ignored.
  - Requests from other channels during XFER are ignored. No preemption.
  - Single requester: it is re-granted after each DONE (IDLE arbitration includes last_ptr itself as the last candidate).
  - All 8 requesting: grants cycle 0,1,...,7,0.
  - grant_idx holds its last value when grant_valid=0. The downstream decoder output must be qualified by grant_valid.
- Widths:
  - cnt is BURST_W+1 bits to hold 16.
  - The timeout counter is clog2(TIMEOUT) bits and saturates; it does not wrap.

Decomposition:
- Shared package dma_pkg holds:
  - state enum {IDLE, XFER, DONE}
  - N_CH and CH_IDX_W=3 constants
  - a function rr_next(req, last_ptr) returning the 3-bit winner and a found flag.
- One natural sub-module: rr_priority_pick, a combinational rotate-and-priority-encode. The FSM, counters and registers stay in dma_channel_arbiter.

Test Plan:
- Reset then req=8'b0000_0100, burst_len=3, beat every cycle:
  - grant_valid rises 1 cycle after req with grant_idx=2.
  - done=1, done_err=0 after the 3rd beat.
  - grant_valid stays high for exactly 3 cycles.
- req=8'hFF held, burst_len=1, beat always 1: grant_idx sequence is 0,1,2,...,7,0, each separated by one DONE cycle.
- burst_len=0, single requester ch5: exactly 16 beats accepted before done; 15 beats leave grant_valid=1.
- Grant ch3 with burst_len=4, assert abort on beat 2 with beat=1: next cycle done=1, done_err=1. Next grant goes to the next requester above 3.
- Grant ch6, hold beat=0: done=1, done_err=1 after TIMEOUT cycles. Request drop on ch6 mid-burst likewise gives done_err=1.
- Assert reset during XFER of ch4:
  - next cycle grant_valid=0, done=0.
  - with req=8'h11, first grant after release is ch0 (last_ptr back to 7).

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel arbiter.
//   - dma_state_e : arbiter FSM states (IDLE, XFER, DONE)
//   - N_CH / CH_IDX_W : channel count and index width (8 channels, 3-bit index
//     so the grant feeds the existing 3-to-8 decoder directly)
//   - rr_pick_t / rr_next() : round-robin winner search starting one past
//     last_ptr, wrapping 7->0, with last_ptr itself as the final candidate.
package dma_pkg;

  localparam int N_CH     = 8;
  localparam int CH_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  typedef struct packed {
    logic                found;
    logic [CH_IDX_W-1:0] idx;
  } rr_pick_t;

  // Rotate the request vector so the slot after last_ptr sits at bit 0, then
  // priority-encode from the bottom. Bit N_CH-1 of the rotated vector is
  // last_ptr itself, so a lone requester always wins again.
  function automatic rr_pick_t rr_next(input logic [N_CH-1:0]     req,
                                       input logic [CH_IDX_W-1:0] last_ptr);
    rr_pick_t              pick;
    logic [CH_IDX_W-1:0]   start;
    logic [2*N_CH-1:0]     dbl;
    logic [N_CH-1:0]       rot;
    start      = last_ptr + CH_IDX_W'(1);
    dbl        = {req, req} >> start;
    rot        = dbl[N_CH-1:0];
    pick.found = |req;
    pick.idx   = last_ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) pick.idx = start + CH_IDX_W'(k);
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate-and-priority-encode of the request
// vector relative to the last granted channel.
// Ports:
//   i_req      - request vector, bit i = channel i
//   i_last_ptr - channel granted most recently (search starts one above it)
//   o_idx      - winning channel index (holds i_last_ptr when nothing is set)
//   o_found    - at least one request is set
module rr_priority_pick
  import dma_pkg::*;
(
  input  logic [N_CH-1:0]     i_req,
  input  logic [CH_IDX_W-1:0] i_last_ptr,
  output logic [CH_IDX_W-1:0] o_idx,
  output logic                o_found
);

  rr_pick_t w_pick;

  assign w_pick  = rr_next(i_req, i_last_ptr);
  assign o_idx   = w_pick.idx;
  assign o_found = w_pick.found;

endmodule

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter for 8 DMA channel request lines. A winner is held for a
// burst of beats (burst_len, 0 meaning 2^BURST_W), then released through a
// one-cycle DONE state before the next arbitration.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   req[7:0]       - level request per channel
//   burst_len      - beats for the next grant, captured on IDLE->XFER
//   beat           - datapath completed one beat for the granted channel
//   abort          - abort the current burst
//   grant_idx[2:0] - granted channel index for the 3-to-8 decoder
//   grant_valid    - grant_idx owns the bus (XFER)
//   done/done_err  - end-of-burst pulse and its error qualifier
//   busy           - XFER or DONE
//   o_dbg_state    - current FSM state
// Handshake: grant_idx is meaningful only while grant_valid is high; it holds
// its last value otherwise. done_err is meaningful only while done is high.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     req,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic                beat,
  input  logic                abort,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                grant_valid,
  output logic                done,
  output logic                done_err,
  output logic                busy,
  output logic [1:0]          o_dbg_state
);

  localparam int CNT_W = BURST_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [1:0]       ST_IDLE = IDLE;
  localparam logic [1:0]       ST_XFER = XFER;
  localparam logic [1:0]       ST_DONE = DONE;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = '1;

  logic [1:0]          r_state;
  logic [CH_IDX_W-1:0] r_grant_idx;
  logic [CH_IDX_W-1:0] r_last_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [TO_W-1:0]     r_to;
  logic                r_err;

  logic [CH_IDX_W-1:0] w_pick_idx;
  logic                w_pick_found;
  logic [CNT_W-1:0]    w_burst_cnt;
  logic [TO_W-1:0]     w_to_inc;

  rr_priority_pick u_pick (
    .i_req      (req),
    .i_last_ptr (r_last_ptr),
    .o_idx      (w_pick_idx),
    .o_found    (w_pick_found)
  );

  // burst_len == 0 stands for the full 2^BURST_W beats.
  assign w_burst_cnt = (burst_len == '0) ? CNT_W'(1 << BURST_W) : {1'b0, burst_len};

  // Idle-cycle counter saturates rather than wrapping.
  assign w_to_inc = (r_to == TO_MAX) ? r_to : r_to + TO_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_last_ptr  <= CH_IDX_W'(N_CH - 1);
      r_cnt       <= '0;
      r_to        <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant_idx <= w_pick_idx;
            r_cnt       <= w_burst_cnt;
            r_to        <= '0;
            r_err       <= 1'b0;
            r_state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          // abort and request drop outrank a coincident final beat.
          if (abort || !req[r_grant_idx]) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else if (beat) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_to  <= '0;
            if (r_cnt == CNT_W'(1)) begin
              r_err   <= 1'b0;
              r_state <= ST_DONE;
            end
          end else begin
            r_to <= w_to_inc;
            if (w_to_inc == TO_LAST) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // No arbitration here: guarantees one idle cycle between bursts.
          r_last_ptr <= r_grant_idx;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_idx   = r_grant_idx;
  assign grant_valid = (r_state == ST_XFER);
  assign done        = (r_state == ST_DONE);
  assign done_err    = done & r_err;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter. Expected grants and burst endings
// are queued when stimulus is applied and retired by the per-cycle monitor.
module tb_dma_channel_arbiter;
  import dma_pkg::*;

  localparam int TIMEOUT = 32;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [3:0] burst_len;
  logic       beat;
  logic       abort;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       done;
  logic       done_err;
  logic       busy;
  logic [1:0] o_dbg_state;

  always #5 clk = ~clk;

  dma_channel_arbiter #(.BURST_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .burst_len   (burst_len),
    .beat        (beat),
    .abort       (abort),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .done        (done),
    .done_err    (done_err),
    .busy        (busy),
    .o_dbg_state (o_dbg_state)
  );

  // scoreboard
  logic [2:0] exp_grant_q[$];
  logic [3:0] exp_done_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic prev_gv    = 1'b0;
  logic grant_rose = 1'b0;
  int n;
  int grants;
  int last_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock; outputs sampled on the falling edge, then the monitor retires
  // queued expectations on grant rise and on done.
  task automatic tick();
    @(negedge clk);
    cyc++;
    grant_rose = grant_valid && !prev_gv;
    prev_gv    = grant_valid;
    check("busy_decode", busy, grant_valid | done);
    if (grant_rose) begin
      check("grant_expected", exp_grant_q.size() != 0, 1);
      if (exp_grant_q.size() != 0) check("grant_idx", grant_idx, exp_grant_q.pop_front());
    end
    if (done) begin
      check("done_expected", exp_done_q.size() != 0, 1);
      if (exp_done_q.size() != 0) check("done_err_idx", {done_err, grant_idx}, exp_done_q.pop_front());
    end
  endtask

  task automatic wait_grant(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!grant_rose && k < 64);
    check(tag, grant_rose, 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!done && k < 64);
    check(tag, done, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (busy && k < 16);
    check(tag, busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; req = '0; burst_len = '0; beat = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check("rst_grant_valid", grant_valid, 0);
    check("rst_done", done, 0);
    check("rst_done_err", done_err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_state", o_dbg_state, IDLE);
    reset = 1'b0;

    // single requester ch2, 3-beat burst, beat every cycle
    req = 8'h04; burst_len = 4'd3; beat = 1'b1;
    exp_grant_q.push_back(3'd2); exp_done_q.push_back({1'b0, 3'd2});
    tick();
    check("t1_latency_gv", grant_valid, 1);
    n = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (grant_valid) n++;
    end
    check("t1_done", done, 1);
    check("t1_done_err", done_err, 0);
    check("t1_gv_cycles", n, 3);
    req = '0; beat = 1'b0;
    wait_idle("t1_idle");

    // all channels requesting: 0..7,0 with DONE+IDLE between grants
    do_reset();
    req = 8'hFF; burst_len = 4'd1; beat = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_grant_q.push_back(3'(k % 8));
      exp_done_q.push_back({1'b0, 3'(k % 8)});
    end
    grants = 0; last_cyc = 0;
    for (int i = 0; i < 60 && grants < 9; i++) begin
      tick();
      if (grant_rose) begin
        if (grants > 0) check("t2_rr_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        grants++;
      end
    end
    check("t2_grant_count", grants, 9);
    tick();
    check("t2_last_done", done, 1);
    req = '0; beat = 1'b0;
    wait_idle("t2_idle");

    // burst_len=0 on ch5 means 16 beats
    req = 8'h20; burst_len = 4'd0; beat = 1'b0;
    exp_grant_q.push_back(3'd5); exp_done_q.push_back({1'b0, 3'd5});
    wait_grant("t3_grant");
    beat = 1'b1;
    repeat (15) tick();
    check("t3_15beats_gv", grant_valid, 1);
    check("t3_15beats_done", done, 0);
    tick();
    check("t3_16beats_done", done, 1);
    // lone requester is granted again
    burst_len = 4'd1;
    exp_grant_q.push_back(3'd5); exp_done_q.push_back({1'b0, 3'd5});
    wait_grant("t3_regrant");
    tick();
    req = '0; beat = 1'b0;
    wait_idle("t3_idle");

    // abort on beat 2 of ch3, next grant goes above 3
    do_reset();
    req = 8'h48; burst_len = 4'd4; beat = 1'b1;
    exp_grant_q.push_back(3'd3); exp_done_q.push_back({1'b1, 3'd3});
    wait_grant("t4_grant3");
    tick();
    abort = 1'b1;
    tick();
    check("t4_abort_done", done, 1);
    check("t4_abort_err", done_err, 1);
    abort = 1'b0;
    exp_grant_q.push_back(3'd6); exp_done_q.push_back({1'b0, 3'd6});
    wait_grant("t4_grant6");
    req = 8'h40;
    wait_done("t4_done6");
    req = '0; beat = 1'b0;
    wait_idle("t4_idle");

    // timeout on ch6 with no beats; the burst ends with DONE as its TIMEOUT-th cycle
    req = 8'h40; burst_len = 4'd4; beat = 1'b0;
    exp_grant_q.push_back(3'd6); exp_done_q.push_back({1'b1, 3'd6});
    wait_grant("t5_grant");
    n = 1;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      if (grant_valid) n++;
    end
    check("t5_to_done", done, 1);
    check("t5_to_err", done_err, 1);
    check("t5_to_gv_cycles", n, TIMEOUT - 1);
    // request drop coinciding with the final beat still reports an error
    burst_len = 4'd2;
    exp_grant_q.push_back(3'd6); exp_done_q.push_back({1'b1, 3'd6});
    wait_grant("t5_regrant");
    beat = 1'b1;
    tick();
    req = '0;
    tick();
    check("t5_drop_done", done, 1);
    check("t5_drop_err", done_err, 1);
    beat = 1'b0;
    wait_idle("t5_idle");

    // reset during the ch4 burst abandons it without done
    req = 8'h10; burst_len = 4'd8; beat = 1'b1;
    exp_grant_q.push_back(3'd4);
    wait_grant("t6_grant4");
    tick();
    reset = 1'b1;
    tick();
    check("t6_rst_gv", grant_valid, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_state", o_dbg_state, IDLE);
    req = 8'h11;
    tick();
    reset = 1'b0;
    exp_grant_q.push_back(3'd0); exp_done_q.push_back({1'b0, 3'd0});
    wait_grant("t6_grant0");
    req = 8'h01;
    wait_done("t6_done0");
    req = '0; beat = 1'b0;
    wait_idle("t6_idle");

    check("grant_q_drained", exp_grant_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
